// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing / test-pattern generator:
// pattern mode encodings, bar colour table and line/frame length helpers.
package video_timing_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_CHECK = 2'd3
  } mode_t;

  localparam int         NUM_BARS = 8;
  localparam logic [2:0] BAR_LAST = 3'(NUM_BARS - 1);

  // {r,g,b} on/off bits for each colour bar, left to right.
  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;  // white
      3'd1:    return 3'b110;  // yellow
      3'd2:    return 3'b011;  // cyan
      3'd3:    return 3'b010;  // green
      3'd4:    return 3'b101;  // magenta
      3'd5:    return 3'b100;  // red
      3'd6:    return 3'b001;  // blue
      default: return 3'b000;  // black
    endcase
  endfunction

  function automatic int line_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster counters with combinational region flags.
// 'run' stays low for the first enabled cycle after reset so the output stage sees an idle slot.
module video_timing_cnt
  import video_timing_pkg::*;
#(
  parameter int H_RES  = 1280,
  parameter int H_FP   = 8,
  parameter int H_SYNC = 2,
  parameter int H_BP   = 8,
  parameter int V_RES  = 720,
  parameter int V_FP   = 8,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 8,
  parameter int CNT_W  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             run,
  output logic             active,
  output logic             hs_act,
  output logic             vs_act,
  output logic             origin,
  output logic             line_end
);

  localparam int H_TOT = line_total(H_RES, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = line_total(V_RES, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_RES + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_RES + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_RES + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_RES + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_RES);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_RES);

  // NOTE: reset is sampled on the clock edge and takes priority over ce,
  // so a reset pulse is honoured even while the pixel enable is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
      run  <= 1'b0;
    end else if (ce) begin
      if (!run) begin
        run <= 1'b1;
      end else if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign line_end = (hcnt == H_LAST);
  assign origin   = (hcnt == '0) && (vcnt == '0);
  assign active   = run && (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
  assign hs_act   = run && (hcnt >= HS_START) && (hcnt < HS_END);
  assign vs_act   = run && (vcnt >= VS_START) && (vcnt < VS_END);

endmodule

// File: rtl/video_timing_gen.sv
// Video timing and test-pattern generator: one registered output stage driven
// by the raster counters, with a frame-latched pattern mode and solid colour.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_RES  = 1280,
  parameter int H_FP   = 8,
  parameter int H_SYNC = 2,
  parameter int H_BP   = 8,
  parameter int V_RES  = 720,
  parameter int V_FP   = 8,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 8,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int PIX_W  = 8,
  parameter int CNT_W  = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [1:0]         mode,
  input  logic [3*PIX_W-1:0] solid_rgb,
  output logic               de,
  output logic               hs,
  output logic               vs,
  output logic [PIX_W-1:0]   r,
  output logic [PIX_W-1:0]   g,
  output logic [PIX_W-1:0]   b,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               sof,
  output logic [7:0]         frame_cnt
);

  localparam int               BAR_W     = (H_RES >= NUM_BARS) ? H_RES / NUM_BARS : 1;
  localparam logic [CNT_W-1:0] BAR_LAST_PIX = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_RES);

  logic [CNT_W-1:0]   hcnt, vcnt;
  logic               run, active, hs_act, vs_act, origin, line_end;

  mode_t              mode_q, mode_eff;
  logic [3*PIX_W-1:0] solid_q, solid_eff;
  logic               seen_sof, sof_nxt;
  logic [7:0]         frame_nxt;
  logic [2:0]         bar_idx;
  logic [CNT_W-1:0]   bar_pix;
  logic [2:0]         bar_bits;
  logic [CNT_W-1:0]   chk_sum;
  logic               chk_cell;
  logic [PIX_W-1:0]   pix_r, pix_g, pix_b;

  video_timing_cnt #(
    .H_RES (H_RES), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_RES (V_RES), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .run      (run),
    .active   (active),
    .hs_act   (hs_act),
    .vs_act   (vs_act),
    .origin   (origin),
    .line_end (line_end)
  );

  // At the frame origin the live inputs bypass the latch, so the first pixel of
  // a frame already uses the newly sampled mode, colour and frame number.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mode_eff  = origin ? mode_t'(mode) : mode_q;
    solid_eff = origin ? solid_rgb : solid_q;
    sof_nxt   = run && origin;
    frame_nxt = (sof_nxt && seen_sof) ? frame_cnt + 8'd1 : frame_cnt;
    chk_sum   = hcnt + CNT_W'(frame_nxt);
    chk_cell  = chk_sum[3] ^ vcnt[3];
    bar_bits  = bar_color(bar_idx);
    pix_r     = '0;
    pix_g     = '0;
    pix_b     = '0;
    if (active) begin
      case (mode_eff)
        MODE_SOLID: {pix_r, pix_g, pix_b} = solid_eff;
        MODE_RAMP: begin
          pix_r = PIX_W'(hcnt);
          pix_g = PIX_W'(hcnt);
          pix_b = PIX_W'(hcnt);
        end
        MODE_BARS: begin
          pix_r = {PIX_W{bar_bits[2]}};
          pix_g = {PIX_W{bar_bits[1]}};
          pix_b = {PIX_W{bar_bits[0]}};
        end
        MODE_CHECK: begin
          pix_r = {PIX_W{~chk_cell}};
          pix_g = {PIX_W{~chk_cell}};
          pix_b = {PIX_W{~chk_cell}};
        end
      endcase
    end
  end

  // Bar position tracks the current hcnt; counting BAR_W pixels avoids a divider.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bar_idx <= '0;
      bar_pix <= '0;
    end else if (ce) begin
      if (!run || line_end) begin
        bar_idx <= '0;
        bar_pix <= '0;
      end else if (hcnt < H_ACT_END) begin
        if (bar_pix == BAR_LAST_PIX) begin
          bar_pix <= '0;
          if (bar_idx != BAR_LAST) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pix <= bar_pix + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q    <= MODE_SOLID;
      solid_q   <= '0;
      seen_sof  <= 1'b0;
      frame_cnt <= '0;
      de        <= 1'b0;
      hs        <= ~HS_POL;
      vs        <= ~VS_POL;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      x         <= '0;
      y         <= '0;
      sof       <= 1'b0;
    end else if (ce) begin
      if (origin) begin
        mode_q  <= mode_t'(mode);
        solid_q <= solid_rgb;
      end
      if (sof_nxt) seen_sof <= 1'b1;
      frame_cnt <= frame_nxt;
      de        <= active;
      hs        <= hs_act ? HS_POL : ~HS_POL;
      vs        <= vs_act ? VS_POL : ~VS_POL;
      r         <= pix_r;
      g         <= pix_g;
      b         <= pix_b;
      x         <= hcnt;
      y         <= vcnt;
      sof       <= sof_nxt;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: a 16x8 raster (22x12 total) in solid/checker/ramp modes
// and a 20-pixel-wide raster in colour-bar mode, sharing clock, reset and ce.
module tb_video_timing_gen;

  localparam logic [23:0] S  = 24'h123456;
  localparam logic [23:0] WH = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n, ce;
  logic [1:0]  mode_a, mode_b;
  logic [23:0] solid_a, solid_b;

  logic        de_a, hs_a, vs_a, sof_a, de_b, hs_b, vs_b, sof_b;
  logic [7:0]  r_a, g_a, b_a, fc_a, r_b, g_b, b_b, fc_b;
  logic [10:0] x_a, y_a, x_b, y_b;

  int n_checks = 0;
  int n_fail   = 0;
  int p_cur    = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_RES (16), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_RES (8),  .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .ce (ce), .mode (mode_a), .solid_rgb (solid_a),
    .de (de_a), .hs (hs_a), .vs (vs_a), .r (r_a), .g (g_a), .b (b_a),
    .x (x_a), .y (y_a), .sof (sof_a), .frame_cnt (fc_a)
  );

  video_timing_gen #(
    .H_RES (20), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_RES (8),  .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .ce (ce), .mode (mode_b), .solid_rgb (solid_b),
    .de (de_b), .hs (hs_b), .vs (vs_b), .r (r_b), .g (g_b), .b (b_b),
    .x (x_b), .y (y_b), .sof (sof_b), .frame_cnt (fc_b)
  );

  typedef struct {
    int          k;
    logic [3:0]  fl;   // {de,hs,vs,sof}
    logic [7:0]  fc;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_a_t;

  typedef struct {
    int          k;
    logic        de;
    logic [23:0] rgb;
  } vec_b_t;

  vec_a_t tab_a[$];
  vec_b_t tab_b[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [3:0] fl, input logic [7:0] fc,
                         input int ex, input int ey, input logic [23:0] rgb);
    check({tag, " flags"}, 64'({de_a, hs_a, vs_a, sof_a}), 64'(fl));
    check({tag, " frame_cnt"}, 64'(fc_a), 64'(fc));
    check({tag, " xy"}, 64'({x_a, y_a}), 64'({ex[10:0], ey[10:0]}));
    check({tag, " rgb"}, 64'({r_a, g_a, b_a}), 64'(rgb));
  endtask

  task automatic adv_to(input int target);
    repeat (target - p_cur) tick();
    p_cur = target;
  endtask

  initial begin
    int ia, ib;

    // k = clock edges after rst_n rises; pixel index p = k-2.
    tab_a.push_back(vec_a_t'{1,   4'b0110, 8'd0, 0,  0,  24'h0});
    tab_a.push_back(vec_a_t'{2,   4'b1111, 8'd0, 0,  0,  S});
    tab_a.push_back(vec_a_t'{3,   4'b1110, 8'd0, 1,  0,  S});
    tab_a.push_back(vec_a_t'{17,  4'b1110, 8'd0, 15, 0,  S});
    tab_a.push_back(vec_a_t'{18,  4'b0110, 8'd0, 16, 0,  24'h0});
    tab_a.push_back(vec_a_t'{20,  4'b0010, 8'd0, 18, 0,  24'h0});
    tab_a.push_back(vec_a_t'{21,  4'b0010, 8'd0, 19, 0,  24'h0});
    tab_a.push_back(vec_a_t'{22,  4'b0110, 8'd0, 20, 0,  24'h0});
    tab_a.push_back(vec_a_t'{23,  4'b0110, 8'd0, 21, 0,  24'h0});
    tab_a.push_back(vec_a_t'{24,  4'b1110, 8'd0, 0,  1,  S});
    tab_a.push_back(vec_a_t'{171, 4'b1110, 8'd0, 15, 7,  S});
    tab_a.push_back(vec_a_t'{178, 4'b0110, 8'd0, 0,  8,  24'h0});
    tab_a.push_back(vec_a_t'{200, 4'b0100, 8'd0, 0,  9,  24'h0});
    tab_a.push_back(vec_a_t'{218, 4'b0000, 8'd0, 18, 9,  24'h0});
    tab_a.push_back(vec_a_t'{243, 4'b0100, 8'd0, 21, 10, 24'h0});
    tab_a.push_back(vec_a_t'{244, 4'b0110, 8'd0, 0,  11, 24'h0});
    tab_a.push_back(vec_a_t'{266, 4'b1111, 8'd1, 0,  0,  S});
    tab_a.push_back(vec_a_t'{267, 4'b1110, 8'd1, 1,  0,  S});

    // Colour bars, 2 px each over a 20-pixel line; pixels 14..19 black.
    tab_b.push_back(vec_b_t'{2,  1'b1, WH});
    tab_b.push_back(vec_b_t'{3,  1'b1, WH});
    tab_b.push_back(vec_b_t'{4,  1'b1, 24'hFFFF00});
    tab_b.push_back(vec_b_t'{6,  1'b1, 24'h00FFFF});
    tab_b.push_back(vec_b_t'{8,  1'b1, 24'h00FF00});
    tab_b.push_back(vec_b_t'{10, 1'b1, 24'hFF00FF});
    tab_b.push_back(vec_b_t'{12, 1'b1, 24'hFF0000});
    tab_b.push_back(vec_b_t'{14, 1'b1, 24'h0000FF});
    tab_b.push_back(vec_b_t'{15, 1'b1, 24'h0000FF});
    tab_b.push_back(vec_b_t'{16, 1'b1, 24'h000000});
    tab_b.push_back(vec_b_t'{18, 1'b1, 24'h000000});
    tab_b.push_back(vec_b_t'{21, 1'b1, 24'h000000});
    tab_b.push_back(vec_b_t'{22, 1'b0, 24'h000000});
    tab_b.push_back(vec_b_t'{29, 1'b1, WH});
    tab_b.push_back(vec_b_t'{30, 1'b1, 24'hFFFF00});

    rst_n   = 1'b0;
    ce      = 1'b1;
    mode_a  = 2'd0;
    mode_b  = 2'd2;
    solid_a = S;
    solid_b = 24'hABCDEF;

    repeat (3) tick();
    check_a("reset", 4'b0110, 8'd0, 0, 0, 24'h0);
    check("b reset sync", 64'({de_b, hs_b, vs_b}), 64'(3'b011));

    rst_n = 1'b1;
    ia = 0;
    ib = 0;
    for (int k = 1; k <= 267; k++) begin
      tick();
      while (ia < tab_a.size() && tab_a[ia].k == k) begin
        check_a($sformatf("a k%0d", k), tab_a[ia].fl, tab_a[ia].fc,
                tab_a[ia].x, tab_a[ia].y, tab_a[ia].rgb);
        ia++;
      end
      while (ib < tab_b.size() && tab_b[ib].k == k) begin
        check($sformatf("b k%0d de_rgb", k), 64'({de_b, r_b, g_b, b_b}),
              64'({tab_b[ib].de, tab_b[ib].rgb}));
        ib++;
      end
    end
    p_cur = 265;

    // Mid-frame switch to checkerboard: takes effect at the next frame.
    mode_a = 2'd3;
    adv_to(286);  check_a("m3 same frame", 4'b1110, 8'd1, 0, 1, S);
    adv_to(528);  check_a("f2 origin",     4'b1111, 8'd2, 0, 0, WH);
    adv_to(533);  check_a("f2 x5",         4'b1110, 8'd2, 5, 0, WH);
    adv_to(534);  check_a("f2 x6",         4'b1110, 8'd2, 6, 0, 24'h0);
    adv_to(796);  check_a("f3 x4",         4'b1110, 8'd3, 4, 0, WH);
    adv_to(797);  check_a("f3 x5",         4'b1110, 8'd3, 5, 0, 24'h0);
    adv_to(2112); check_a("f8 origin",     4'b1111, 8'd8, 0, 0, 24'h0);

    mode_a = 2'd1;
    adv_to(2376); check_a("f9 ramp x0",  4'b1111, 8'd9, 0,  0, 24'h0);
    adv_to(2389); check_a("f9 ramp x13", 4'b1110, 8'd9, 13, 0, 24'h0D0D0D);

    // Half-rate enable: 44 clocks cover one 22-pixel line.
    for (int i = 0; i < 44; i++) begin
      ce = (i % 2 == 0);
      tick();
      if (i == 1) check_a("ce hold x14", 4'b1110, 8'd9, 14, 0, 24'h0E0E0E);
      if (i == 3) check_a("ce hold x15", 4'b1110, 8'd9, 15, 0, 24'h0F0F0F);
    end
    ce = 1'b1;
    p_cur = 2411;
    check_a("ce line", 4'b1110, 8'd9, 13, 1, 24'h0D0D0D);

    // Reset during an hsync pulse on line 5, with ce low.
    adv_to(2504); check_a("pre reset", 4'b0010, 8'd9, 18, 5, 24'h0);
    mode_a = 2'd0;
    rst_n  = 1'b0;
    ce     = 1'b0;
    tick(); check_a("mid reset", 4'b0110, 8'd0, 0, 0, 24'h0);
    rst_n = 1'b1;
    ce    = 1'b1;
    tick(); check_a("rel k1", 4'b0110, 8'd0, 0, 0, 24'h0);
    tick(); check_a("rel k2", 4'b1111, 8'd0, 0, 0, S);
    ce = 1'b0;
    tick(); check_a("sof hold", 4'b1111, 8'd0, 0, 0, S);
    ce = 1'b1;
    tick(); check_a("after hold", 4'b1110, 8'd0, 1, 0, S);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Synthesisable, parametrised video timing and test-pattern generator for the vision pipeline. It produces DE/HSYNC/VSYNC with configurable resolution, porches and sync polarity, plus an RGB test pattern in one of four runtime-selectable modes. It drives the same pixel-stream interface the centroid/vision IPs consume, and replaces simulation-only, file-driven stimulus with hardware-capable stimulus usable on-board.

## Interface
- H_RES, 1280, active pixels per line
- H_FP, 8, horizontal front porch (pixels)
- H_SYNC, 2, hsync length (pixels)
- H_BP, 8, horizontal back porch (pixels)
- V_RES, 720, active lines per frame
- V_FP, 8, vertical front porch (lines)
- V_SYNC, 4, vsync length (lines)
- V_BP, 8, vertical back porch (lines)
- HS_POL, 0, hs level while sync active (0 = negative, Zybo default)
- VS_POL, 0, vs level while sync active
- PIX_W, 8, bits per colour component
- CNT_W, 11, counter width; must satisfy 2^CNT_W > H_RES+H_FP+H_SYNC+H_BP and > V total
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- ce  in  1  pixel enable; 0 freezes all state and outputs
- mode  in  2  pattern: 0 solid, 1 ramp, 2 colour bars, 3 scrolling checkerboard
- solid_rgb  in  3*PIX_W  {r,g,b} used in mode 0
- de  out  1  active-video flag
- hs  out  1  horizontal sync (polarity HS_POL)
- vs  out  1  vertical sync (polarity VS_POL)
- r, g, b  out  PIX_W each  pixel colour; 0 when de=0
- x, y  out  CNT_W each  coordinate of current output pixel (valid when de=1)
- sof  out  1  one-cycle pulse coincident with pixel (0,0)
- frame_cnt  out  8  completed-frame counter, wraps 255->0

## Operation
- H_TOT = H_RES+H_FP+H_SYNC+H_BP; V_TOT = V_RES+V_FP+V_SYNC+V_BP.
- Line order: active [0,H_RES), front porch, sync [H_RES+H_FP, H_RES+H_FP+H_SYNC), back porch. Same order vertically, in lines.
- hcnt increments on each ce cycle, wraps H_TOT-1 -> 0; vcnt increments when hcnt wraps, wraps V_TOT-1 -> 0.
- vs changes only at hcnt=0 boundaries (line-aligned).
- mode and solid_rgb are sampled only when (hcnt,vcnt)=(0,0) with ce=1; a change mid-frame takes effect at the next frame.
- Mode 1: r=g=b=x[PIX_W-1:0] (wraps every 2^PIX_W pixels).
- Mode 2: BAR_W=H_RES/8 (integer); a bar counter advances every BAR_W active pixels, saturates at 7, resets each line; order white, yellow, cyan, green, magenta, red, blue, black; component = all-ones or 0; remainder pixels (H_RES mod 8) stay black. No divider.
- Mode 3: cell=((x+frame_cnt)>>3 ^ y>>3) & 1; cell 0 -> white, 1 -> black; pattern scrolls one pixel left per frame.
- frame_cnt increments on the cycle sof is asserted, from the second frame after reset onward (first sof after reset shows 0).

## Timing
- Reset (rst_n=0 at posedge clk, regardless of ce): hcnt=vcnt=0, de=0, hs=~HS_POL, vs=~VS_POL, r=g=b=0, x=y=0, sof=0, frame_cnt=0, latched mode=0, solid=0. Reset mid-frame abandons the frame; no partial sync pulse persists.
- One registered output stage: all outputs describe counter state of the previous ce cycle. After rst_n rises, first ce cycle loads counters (0,0); next ce cycle de=1, sof=1, x=y=0.
- de, hs, vs, rgb, x, y, sof mutually aligned in the same cycle; pattern logic must not add skew between colour and de.
- ce=0: no counter, output or frame_cnt change; sof remains high if it was high (pulse is one ce cycle).

## Structure
- Package video_timing_pkg: mode encodings (MODE_SOLID, MODE_RAMP, MODE_BARS, MODE_CHECK), 3-bit bar colour table, total-length constant functions.
- Sub-module video_timing_cnt: h/v counters, sync/active flags, sof; top instantiates it and owns mode latch, bar counter, pattern mux and output register.

## Test plan
- Small params H_RES=16,FP=2,SYNC=2,BP=2; V_RES=8,FP=1,SYNC=2,BP=1; ce=1 -> 22 cycles/line, 264 cycles/frame; de high 16 cycles/line for 8 lines; hs active at hcnt 18-19; vs active lines 9-10.
- Reset release -> de=0, hs=vs inactive during reset; sof and de first 1 exactly 2 cycles after rst_n rises; frame_cnt=0, then 1 at next sof.
- Mode 2, H_RES=20 -> bars 2 px wide, pixels 16-19 black; first pixel white (all ones), pixel 2 yellow (r=g=FF, b=0).
- mode switched 0->3 mid-frame -> current frame stays solid_rgb; checkerboard from next sof; frame k pixel (0,0) colour follows cell of x+k.
- ce toggled 1,0,1,0 -> counters advance half-rate; line length 44 clk; outputs stable during ce=0.
- rst_n pulsed low at vcnt=5 during vs inactive -> outputs reset next cycle; new frame starts at (0,0); frame_cnt back to 0.
